mk14_disp_kbd: RTL and testbench



---
 rtl/mk14_io_pkg.sv | 18 +
 rtl/mk14_kbd_debounce.sv | 39 +++
 rtl/mk14_disp_kbd.sv | 81 ++++++++
 tb/tb_mk14_disp_kbd.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mk14_io_pkg.sv
// mk14_io_pkg: shared constants and helpers for the MK14 display/keypad peripheral
package mk14_io_pkg;
    localparam logic [7:0] IO_PAGE      = 8'h0D;
    localparam int         NUM_DIGITS   = 8;
    localparam int         NUM_ROWS     = 4;
    localparam logic [3:0] KEY_RELEASED = 4'hF;
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;
    function automatic logic [7:0] key_word(input logic [NUM_ROWS-1:0] keys);
        return {keys, 4'hF};
    endfunction
endpackage

// File: rtl/mk14_kbd_debounce.sv
// mk14_kbd_debounce: per-column debouncer committing a row pattern after enough identical samples
module mk14_kbd_debounce
    import mk14_io_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en_i,
    input  logic [NUM_ROWS-1:0] sample_i,
    output logic [NUM_ROWS-1:0] state_o
);
    logic [NUM_ROWS-1:0] last_raw_q, last_raw_d, state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;

    // next state: count repeats of the same sample, restart on any change, commit once stable
    always_comb begin
        last_raw_d = sample_en_i ? sample_i : last_raw_q;
        cnt_d      = !sample_en_i ? cnt_q :
                     (sample_i != last_raw_q) ? 3'd0 :
                     (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
        state_d    = (sample_en_i && cnt_d >= 3'(DEBOUNCE_SCANS - 1)) ? sample_i : state_q;
    end

    // column state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_raw_q <= KEY_RELEASED;
            cnt_q      <= '0;
            state_q    <= KEY_RELEASED;
        end else begin
            last_raw_q <= last_raw_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    assign state_o = state_q;
endmodule

// File: rtl/mk14_disp_kbd.sv
// mk14_disp_kbd: page-0x0D display buffer, multiplexed 7-segment scan and debounced key matrix
module mk14_disp_kbd
    import mk14_io_pkg::*;
#(
    parameter int CLOCK_FREQ_MHZ = 50,
    parameter int SCAN_US        = 1000,
    parameter int BLANK_TICKS    = 16,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [15:0]           mem_addr,
    input  logic                  mem_write_en,
    input  logic [7:0]            mem_write_data,
    output logic                  io_sel,
    output logic [7:0]            io_read_data,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_an,
    input  logic [NUM_ROWS-1:0]   kbd_row
);
    localparam int SLOT = CLOCK_FREQ_MHZ * SCAN_US;
    localparam int TW   = $clog2(SLOT);

    logic [TW-1:0]       tick_q, tick_d;
    logic [2:0]          scan_q, scan_d;
    logic [NUM_ROWS-1:0] sync1_q, sync2_q;
    logic [7:0]          digit_buf_q [NUM_DIGITS];
    logic [7:0]          io_read_data_q, io_read_data_d;
    logic [NUM_ROWS-1:0] key_state [NUM_DIGITS];
    logic                slot_end, blank, valid, unused_addr;

    assign io_sel      = mem_addr[15:8] == IO_PAGE;
    assign valid       = io_sel && !mem_addr[3];
    assign slot_end    = tick_q == TW'(SLOT - 1);
    assign blank       = tick_q < TW'(BLANK_TICKS);
    assign unused_addr = ^mem_addr[7:4];

    // scan timer advance and bus read mux
    always_comb begin
        tick_d         = slot_end ? '0 : tick_q + TW'(1);
        scan_d         = slot_end ? scan_q + 3'd1 : scan_q;
        io_read_data_d = !en ? io_read_data_q : valid ? key_word(key_state[mem_addr[2:0]]) : 8'hFF;
    end

    // scan counters, row synchronizer, read data and digit buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q         <= '0;
            scan_q         <= '0;
            sync1_q        <= KEY_RELEASED;
            sync2_q        <= KEY_RELEASED;
            io_read_data_q <= 8'hFF;
            for (int k = 0; k < NUM_DIGITS; k++) digit_buf_q[k] <= 8'h00;
        end else begin
            tick_q         <= tick_d;
            scan_q         <= scan_d;
            sync1_q        <= kbd_row;
            sync2_q        <= sync1_q;
            io_read_data_q <= io_read_data_d;
            if (en && mem_write_en && valid) digit_buf_q[mem_addr[2:0]] <= mem_write_data;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_col
            mk14_kbd_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
                .clk        (clk),
                .rst        (rst),
                .sample_en_i(slot_end && scan_q == 3'(i)),
                .sample_i   (sync2_q),
                .state_o    (key_state[i])
            );
        end
    endgenerate

    assign io_read_data = io_read_data_q;
    assign seg          = blank ? 8'h00 : digit_buf_q[scan_q];
    assign digit_an     = blank ? '0 : NUM_DIGITS'(1) << scan_q;
endmodule

// File: tb/tb_mk14_disp_kbd.sv
// tb_mk14_disp_kbd: directed self-checking bench for the display/keypad peripheral
module tb_mk14_disp_kbd;
    logic        clk = 1'b0;
    logic        rst, en, io_sel, mem_write_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_write_data, io_read_data, seg, digit_an;
    logic [3:0]  kbd_row;
    int checks = 0;
    int errors = 0;

    mk14_disp_kbd #(
        .CLOCK_FREQ_MHZ(1),
        .SCAN_US       (32),
        .BLANK_TICKS   (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .mem_addr      (mem_addr),
        .mem_write_en  (mem_write_en),
        .mem_write_data(mem_write_data),
        .io_sel        (io_sel),
        .io_read_data  (io_read_data),
        .seg           (seg),
        .digit_an      (digit_an),
        .kbd_row       (kbd_row)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        en = 1'b1; mem_addr = a; mem_write_data = d; mem_write_en = 1'b1;
        @(negedge clk);
        mem_write_en = 1'b0;
    endtask

    task automatic wait_slot(input int n, input string tag);
        logic [7:0] want;
        want = 8'(1) << n;
        for (int c = 0; c < 600 && digit_an !== want; c++) @(negedge clk);
        chk(tag, digit_an, want);
    endtask

    task automatic wait_blank(input string tag);
        for (int c = 0; c < 600 && digit_an !== 8'h00; c++) @(negedge clk);
        chk(tag, digit_an, 8'h00);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mem_addr = 16'h0D03; mem_write_en = 1'b0;
        mem_write_data = 8'h00; kbd_row = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_seg", seg, 8'h00);
        chk("rst_an", digit_an, 8'h00);
        chk("rst_rd", io_read_data, 8'hFF);
        chk("io_sel", {7'd0, io_sel}, 8'h01);
        rst = 1'b0;
        @(negedge clk);
        chk("rd_0d03", io_read_data, 8'hFF);

        bus_write(16'h0D02, 8'h3F);
        bus_write(16'h0DF5, 8'h06);
        bus_write(16'h0D0A, 8'h55);
        chk("rd_hole", io_read_data, 8'hFF);
        mem_addr = 16'h0E02;
        #1 chk("io_sel_off", {7'd0, io_sel}, 8'h00);
        mem_addr = 16'h0D0A;

        wait_slot(2, "an_slot2");
        chk("seg_slot2", seg, 8'h3F);
        wait_blank("blank_slot3_t0");
        chk("seg_blank_t0", seg, 8'h00);
        repeat (3) @(negedge clk);
        chk("an_blank_t3", digit_an, 8'h00);
        chk("seg_blank_t3", seg, 8'h00);
        @(negedge clk);
        chk("an_slot3_t4", digit_an, 8'h08);
        chk("seg_slot3", seg, 8'h00);
        wait_slot(5, "an_slot5");
        chk("seg_slot5", seg, 8'h06);

        mem_addr = 16'h0D04;
        for (int f = 0; f < 3; f++) begin
            wait_slot(4, "an_press");
            kbd_row = 4'b1101;
            wait_blank("blank_press");
            kbd_row = 4'hF;
            repeat (2) @(negedge clk);
            chk($sformatf("press_f%0d", f), io_read_data, (f == 2) ? 8'hDF : 8'hFF);
        end
        mem_addr = 16'h0D03;
        repeat (2) @(negedge clk);
        chk("col3_idle", io_read_data, 8'hFF);

        mem_addr = 16'h0D04;
        for (int f = 0; f < 3; f++) begin
            wait_slot(4, "an_release");
            wait_blank("blank_release");
            repeat (2) @(negedge clk);
            chk($sformatf("release_f%0d", f), io_read_data, (f == 2) ? 8'hFF : 8'hDF);
        end

        wait_slot(4, "an_glitch");
        kbd_row = 4'b0111;
        wait_blank("blank_glitch");
        kbd_row = 4'hF;
        for (int f = 0; f < 3; f++) begin
            repeat (2) @(negedge clk);
            chk($sformatf("glitch_f%0d", f), io_read_data, 8'hFF);
            wait_slot(4, "an_post_glitch");
            wait_blank("blank_post_glitch");
        end

        en = 1'b0; mem_addr = 16'h0D01; mem_write_data = 8'h77; mem_write_en = 1'b1;
        wait_slot(1, "an_en0_scan");
        chk("seg_en0", seg, 8'h00);
        wait_slot(2, "an_en0_slot2");
        chk("seg_en0_slot2", seg, 8'h3F);
        mem_write_en = 1'b0; en = 1'b1;

        wait_slot(6, "an_slot6");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_an", digit_an, 8'h00);
        chk("rst_mid_seg", seg, 8'h00);
        chk("rst_mid_rd", io_read_data, 8'hFF);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_blank_t3", digit_an, 8'h00);
        @(negedge clk);
        chk("rst_slot0_an", digit_an, 8'h01);
        wait_slot(2, "an_cleared2");
        chk("seg_cleared2", seg, 8'h00);
        wait_slot(5, "an_cleared5");
        chk("seg_cleared5", seg, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
